datapath_lane_unpacker: RTL

//  Downstream stage of the 192-bit datapath FIFO. Requests one 192-bit word per FIFO read slot and

---
 rtl/datapath_lane_unpacker.sv | 119 +++++++++++
 1 files changed

// File: rtl/datapath_lane_unpacker.sv
// Lane unpacker: pulls one wide word from the datapath FIFO, then streams it out as
// LANE_WIDTH-bit samples (LSB lane first) on a valid/ready interface.
module datapath_lane_unpacker #(
    parameter int unsigned IN_WIDTH   = 192,
    parameter int unsigned LANE_WIDTH = 16,
    parameter int unsigned NUM_LANES  = 12,
    parameter int unsigned IDX_WIDTH  = 4,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    input  logic                  fifo_rd_stb,
    input  logic [IN_WIDTH-1:0]   fifo_data,
    output logic                  fifo_rd,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [LANE_WIDTH-1:0] m_data,
    output logic [IDX_WIDTH-1:0]  m_index,
    output logic                  m_last,
    output logic                  underrun,
    input  logic                  underrun_clr,
    output logic [CNT_WIDTH-1:0]  word_count
);

    localparam logic [IDX_WIDTH-1:0] LastIdx = IDX_WIDTH'(NUM_LANES - 1);

    typedef enum logic [1:0] {StIdle, StLoad, StShift} state_e;

    state_e                state_q, state_d;
    logic [IN_WIDTH-1:0]   sreg_q, sreg_d;
    logic [IDX_WIDTH-1:0]  idx_q, idx_d;
    logic                  started_q, started_d;
    logic                  underrun_q, underrun_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic                  fifo_rd_q, fifo_rd_d;

    logic accept;
    logic last_lane;

    assign accept    = (state_q == StShift) && m_ready;
    assign last_lane = (idx_q == LastIdx);

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            sreg_q     <= '0;
            idx_q      <= '0;
            started_q  <= 1'b0;
            underrun_q <= 1'b0;
            count_q    <= '0;
            fifo_rd_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sreg_q     <= sreg_d;
            idx_q      <= idx_d;
            started_q  <= started_d;
            underrun_q <= underrun_d;
            count_q    <= count_d;
            fifo_rd_q  <= fifo_rd_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (fifo_rd_stb) state_d = StLoad;
            StLoad:  state_d = StShift;
            StShift: if (accept && last_lane) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Datapath, counters and sticky underrun.
    always_comb begin
        sreg_d    = sreg_q;
        idx_d     = idx_q;
        started_d = started_q;
        count_d   = count_q;
        if (state_q == StLoad) begin
            // fifo_data is registered in the FIFO, so it is valid one cycle after the strobe.
            sreg_d    = fifo_data;
            idx_d     = '0;
            started_d = 1'b1;
        end else if (accept) begin
            if (last_lane) begin
                count_d = count_q + CNT_WIDTH'(1);
            end else begin
                sreg_d = sreg_q >> LANE_WIDTH;
                idx_d  = idx_q + IDX_WIDTH'(1);
            end
        end

        // A strobe in this cycle means the FIFO did deliver, even if it just went empty.
        underrun_d = underrun_q;
        if (underrun_clr) begin
            underrun_d = 1'b0;
        end else if ((state_q == StIdle) && started_q && fifo_empty && !fifo_rd_stb) begin
            underrun_d = 1'b1;
        end

        // Request level follows the state we are about to enter, so it leaves a flop.
        fifo_rd_d = (state_d == StIdle);
    end

    // Outputs decode registered state only; m_ready never reaches m_valid.
    always_comb begin
        m_valid    = (state_q == StShift);
        m_data     = sreg_q[LANE_WIDTH-1:0];
        m_index    = idx_q;
        m_last     = (state_q == StShift) && last_lane;
        fifo_rd    = fifo_rd_q;
        underrun   = underrun_q;
        word_count = count_q;
    end

endmodule
